// File: rtl/spi_master_shifter_pkg.sv
// Shared types and defaults for the SPI master shift engine.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package spi_master_shifter_pkg;

  // Frame sequencer states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_SHIFT = 2'd2,
    ST_HOLD  = 2'd3
  } spi_state_t;

  // Default log2 of the longest frame; data ports are 2**LOG bits wide.
  localparam int SPI_MAX_WIDTH_LOG_DEF = 4;
  // Default number of clk cycles per sclk half-period.
  localparam int HALF_DIV_DEF          = 2;

endpackage

// File: rtl/spi_master_shifter_half_tick.sv
// Half-period timebase: pulses tick once every HALF_DIV enabled cycles.
// Latency: first tick HALF_DIV cycles after en rises; counter held at zero while en is low.
// Backpressure: none; free-running while enabled.
//   clk, rst_n : clock, asynchronous active-low reset
//   en         : count enable (low clears the counter)
//   tick       : high on the last cycle of each half-period
module spi_master_shifter_half_tick #(
  parameter int HALF_DIV = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic tick
);

  localparam int CW = (HALF_DIV > 1) ? $clog2(HALF_DIV) : 1;

  logic [CW-1:0] cnt;

  assign tick = en && (cnt == CW'(HALF_DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (!en || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/spi_master_shifter.sv
// Single-frame SPI master: shifts spi_width+1 bits MSB first and returns the received word.
// Latency: accept in cycle 0, rx_valid in cycle 1+(2N+1)*HALF_DIV with N = spi_width+1.
// Backpressure: tx_ready is high only in IDLE; a frame's settings are frozen at accept.
//   clk, rst_n           : clock, asynchronous active-low reset
//   cpol, cpha, spi_width: bus mode and frame length minus one (sampled at accept)
//   tx_valid/tx_ready    : handshake for tx_data
//   rx_valid, rx_data    : one-cycle pulse with right-aligned received bits
//   busy                 : frame in progress
//   sclk, cs_n, mosi     : registered SPI bus outputs; miso: SPI bus input
module spi_master_shifter
  import spi_master_shifter_pkg::*;
#(
  parameter int SPI_MAX_WIDTH_LOG = SPI_MAX_WIDTH_LOG_DEF,
  parameter int HALF_DIV          = HALF_DIV_DEF
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            cpol,
  input  logic                            cpha,
  input  logic [SPI_MAX_WIDTH_LOG-1:0]    spi_width,
  input  logic                            tx_valid,
  output logic                            tx_ready,
  input  logic [(1<<SPI_MAX_WIDTH_LOG)-1:0] tx_data,
  output logic                            rx_valid,
  output logic [(1<<SPI_MAX_WIDTH_LOG)-1:0] rx_data,
  output logic                            busy,
  output logic                            sclk,
  output logic                            cs_n,
  output logic                            mosi,
  input  logic                            miso
);

  localparam int W = 1 << SPI_MAX_WIDTH_LOG;

  spi_state_t                   state;
  logic                         cpha_q;
  logic [SPI_MAX_WIDTH_LOG-1:0] width_q;
  logic [SPI_MAX_WIDTH_LOG:0]   edge_cnt;   // sclk edges already issued, 0..2N-1
  logic [W-1:0]                 tx_sr;
  logic [W-1:0]                 rx_sr;
  logic [W-1:0]                 tx_aligned;
  logic                         tick;
  logic                         edge_lead;
  logic                         edge_last;
  logic                         edge_sample;
  logic                         edge_drive;

  spi_master_shifter_half_tick #(
    .HALF_DIV (HALF_DIV)
  ) u_half_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (state != ST_IDLE),
    .tick  (tick)
  );

  assign tx_ready = (state == ST_IDLE);
  assign busy     = (state != ST_IDLE);

  // Left-justify the frame so its first bit sits in the MSB of the shifter:
  // W-1-spi_width equals ~spi_width in LOG bits.
  assign tx_aligned = tx_data << ~spi_width;

  // Even edge counts are leading edges; the final edge is trailing edge N.
  assign edge_lead   = ~edge_cnt[0];
  assign edge_last   = (edge_cnt == {width_q, 1'b1});
  assign edge_sample = edge_lead ^ cpha_q;
  // The non-sampling edges move mosi, except the last trailing edge (cpha=0)
  // and the first leading edge (cpha=1), where the MSB is already on the wire.
  assign edge_drive  = ~edge_sample & ~edge_last & (edge_cnt != '0);

  // sclk keeps no separate polarity copy: it is loaded with cpol at accept and
  // toggles an even number of times, so it returns to the frame's idle level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      sclk     <= 1'b0;
      cs_n     <= 1'b1;
      mosi     <= 1'b0;
      rx_valid <= 1'b0;
      rx_data  <= '0;
      cpha_q   <= 1'b0;
      width_q  <= '0;
      edge_cnt <= '0;
      tx_sr    <= '0;
      rx_sr    <= '0;
    end else begin
      rx_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          sclk <= cpol;
          cs_n <= 1'b1;
          mosi <= 1'b0;
          if (tx_valid) begin
            state    <= ST_SETUP;
            cs_n     <= 1'b0;
            mosi     <= tx_aligned[W-1];
            tx_sr    <= tx_aligned;
            rx_sr    <= '0;
            edge_cnt <= '0;
            cpha_q   <= cpha;
            width_q  <= spi_width;
          end
        end
        ST_SETUP, ST_SHIFT: begin
          if (tick) begin
            sclk <= ~sclk;
            if (edge_sample) begin
              rx_sr <= {rx_sr[W-2:0], miso};
            end
            if (edge_drive) begin
              mosi  <= tx_sr[W-2];
              tx_sr <= {tx_sr[W-2:0], 1'b0};
            end
            if (edge_last) begin
              state    <= ST_HOLD;
              edge_cnt <= '0;
            end else begin
              state    <= ST_SHIFT;
              edge_cnt <= edge_cnt + 1'b1;
            end
          end
        end
        ST_HOLD: begin
          if (tick) begin
            state    <= ST_IDLE;
            cs_n     <= 1'b1;
            mosi     <= 1'b0;
            rx_valid <= 1'b1;
            rx_data  <= rx_sr;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master_shifter.sv
// Directed bench for spi_master_shifter with a behavioural SPI slave.
// Latency: n/a.
// Backpressure: n/a.
module tb_spi_master_shifter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cpol, cpha;
  logic [3:0]  spi_width;
  logic        tx_valid;
  logic        tx_ready;
  logic [15:0] tx_data;
  logic        rx_valid;
  logic [15:0] rx_data;
  logic        busy, sclk, cs_n, mosi, miso;

  int n_pass  = 0;
  int n_total = 0;

  // Slave model state.
  logic        s_cpol, s_cpha, s_loop, slave_miso;
  int          s_nbits, s_idx;
  logic [15:0] s_word, s_cap;

  always #5 clk = ~clk;

  assign miso = s_loop ? mosi : slave_miso;

  spi_master_shifter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cpol      (cpol),
    .cpha      (cpha),
    .spi_width (spi_width),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .tx_data   (tx_data),
    .rx_valid  (rx_valid),
    .rx_data   (rx_data),
    .busy      (busy),
    .sclk      (sclk),
    .cs_n      (cs_n),
    .mosi      (mosi),
    .miso      (miso)
  );

  // Slave: presents its word MSB first, captures mosi on the sampling edges.
  always @(negedge cs_n) begin
    s_idx = 0;
    s_cap = '0;
    if (!s_cpha) slave_miso = s_word[s_nbits-1];
  end

  always @(sclk) begin
    if (!cs_n) begin
      if (sclk != s_cpol) begin
        if (!s_cpha) s_cap = {s_cap[14:0], mosi};
        else if (s_idx < s_nbits) slave_miso = s_word[s_nbits-1-s_idx];
      end else begin
        if (s_cpha) s_cap = {s_cap[14:0], mosi};
        s_idx++;
        if (!s_cpha && s_idx < s_nbits) slave_miso = s_word[s_nbits-1-s_idx];
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // One complete frame; optionally disturbs the config inputs mid-frame.
  task automatic run_frame(input string tag, input logic c_pol, input logic c_pha,
                           input logic [3:0] w, input logic [15:0] tx, input logic loop,
                           input logic [15:0] sword, input bit perturb,
                           input logic [15:0] exp_rx, input logic [15:0] exp_cap,
                           input int exp_lat);
    int   lat;
    int   edges;
    logic prev;
    @(negedge clk);
    cpol = c_pol; cpha = c_pha; spi_width = w; tx_data = tx;
    s_cpol = c_pol; s_cpha = c_pha; s_nbits = int'(w) + 1; s_word = sword; s_loop = loop;
    @(negedge clk);
    chk({tag, ".idle_sclk"}, 32'(sclk), 32'(c_pol));
    chk({tag, ".ready"}, 32'(tx_ready), 32'd1);
    tx_valid = 1'b1;
    lat   = -1;
    edges = 0;
    prev  = sclk;
    for (int c = 1; c <= 200; c++) begin
      @(negedge clk);
      if (c == 1) begin
        tx_valid = 1'b0;
        chk({tag, ".setup"}, 32'({cs_n, mosi, sclk}), 32'({1'b0, tx[w], c_pol}));
      end
      if (perturb && c == 10) begin
        cpol = ~c_pol; cpha = ~c_pha; spi_width = 4'd3; tx_data = ~tx;
      end
      if (sclk !== prev) edges++;
      prev = sclk;
      if (rx_valid) begin
        lat = c;
        break;
      end
    end
    chk({tag, ".latency"}, lat, exp_lat);
    chk({tag, ".edges"}, edges, 2 * (int'(w) + 1));
    chk({tag, ".rx"}, 32'(rx_data), 32'(exp_rx));
    chk({tag, ".mosi_seq"}, 32'(s_cap), 32'(exp_cap));
    chk({tag, ".end_bus"}, 32'({cs_n, sclk, busy}), 32'({1'b1, c_pol, 1'b0}));
    @(negedge clk);
    chk({tag, ".pulse"}, 32'(rx_valid), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] words [3];
    logic [15:0] got   [3];
    int n_acc, n_rx, cyc, cs_hi, rdy_hi, t_end, rx_cnt;
    bit pend;

    rst_n = 1'b0; cpol = 1'b0; cpha = 1'b0; spi_width = 4'd0;
    tx_valid = 1'b0; tx_data = '0;
    s_cpol = 1'b0; s_cpha = 1'b0; s_loop = 1'b0; slave_miso = 1'b0;
    s_nbits = 1; s_idx = 0; s_word = '0; s_cap = '0;

    #12;
    chk("reset.bus", 32'({sclk, cs_n, mosi, rx_valid, busy, tx_ready}), 32'(6'b010001));
    chk("reset.rx_data", 32'(rx_data), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_frame("m0_loop", 1'b0, 1'b0, 4'd7,  16'h00A5, 1'b1, 16'h0000, 1'b0, 16'h00A5, 16'h00A5, 35);
    run_frame("m1",      1'b0, 1'b1, 4'd7,  16'h003C, 1'b0, 16'h003C, 1'b0, 16'h003C, 16'h003C, 35);
    run_frame("m2",      1'b1, 1'b0, 4'd7,  16'h003C, 1'b0, 16'h003C, 1'b0, 16'h003C, 16'h003C, 35);
    run_frame("m3",      1'b1, 1'b1, 4'd7,  16'h003C, 1'b0, 16'h003C, 1'b0, 16'h003C, 16'h003C, 35);
    run_frame("w15",     1'b0, 1'b0, 4'd15, 16'hBEEF, 1'b0, 16'h1234, 1'b0, 16'h1234, 16'hBEEF, 67);
    run_frame("w0_m0",   1'b0, 1'b0, 4'd0,  16'hFFFE, 1'b0, 16'h0001, 1'b0, 16'h0001, 16'h0000, 7);
    run_frame("w0_m3",   1'b1, 1'b1, 4'd0,  16'h8001, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0001, 7);
    run_frame("perturb", 1'b0, 1'b0, 4'd7,  16'h005A, 1'b0, 16'h0096, 1'b1, 16'h0096, 16'h005A, 35);
    run_frame("after",   1'b1, 1'b1, 4'd3,  16'h0009, 1'b0, 16'h0006, 1'b0, 16'h0006, 16'h0009, 19);

    // Back-to-back: tx_valid held across three 4-bit loopback frames.
    words[0] = 16'h0003; words[1] = 16'h000A; words[2] = 16'h0005;
    got[0] = 'x; got[1] = 'x; got[2] = 'x;
    @(negedge clk);
    cpol = 1'b0; cpha = 1'b0; spi_width = 4'd3;
    s_cpol = 1'b0; s_cpha = 1'b0; s_nbits = 4; s_loop = 1'b1;
    tx_data = words[0]; tx_valid = 1'b1;
    n_acc = 0; n_rx = 0; cyc = -1; cs_hi = 0; rdy_hi = 0; t_end = -1; pend = 1'b0;
    for (int c = 0; c < 300 && n_rx < 3; c++) begin
      if (c > 0) @(negedge clk);
      if (pend) begin
        if (n_acc < 3) tx_data = words[n_acc];
        else tx_valid = 1'b0;
        pend = 1'b0;
      end
      if (cyc >= 0) cyc++;
      if (rx_valid) begin
        got[n_rx] = rx_data;
        n_rx++;
        if (n_rx == 3) t_end = cyc;
      end
      if (cyc >= 1 && n_rx < 3) begin
        cs_hi  += int'(cs_n);
        rdy_hi += int'(tx_ready);
      end
      if (tx_valid && tx_ready) begin
        if (n_acc == 0) cyc = 0;
        n_acc++;
        pend = 1'b1;
      end
    end
    tx_valid = 1'b0;
    chk("b2b.rx0", 32'(got[0]), 32'h0003);
    chk("b2b.rx1", 32'(got[1]), 32'h000A);
    chk("b2b.rx2", 32'(got[2]), 32'h0005);
    chk("b2b.accepts", n_acc, 3);
    chk("b2b.end_cycle", t_end, 57);
    chk("b2b.cs_high_cycles", cs_hi, 2);
    chk("b2b.ready_cycles", rdy_hi, 2);

    // Reset pulse in the middle of a mode-2 frame.
    @(negedge clk);
    cpol = 1'b1; cpha = 1'b0; spi_width = 4'd7; tx_data = 16'h00F0;
    s_cpol = 1'b1; s_cpha = 1'b0; s_nbits = 8; s_word = 16'h00FF; s_loop = 1'b0;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    repeat (11) @(negedge clk);
    chk("rst.busy_before", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rst.bus", 32'({sclk, cs_n, mosi, rx_valid, busy, tx_ready}), 32'(6'b010001));
    chk("rst.rx_data", 32'(rx_data), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    rx_cnt = 0;
    repeat (40) begin
      @(negedge clk);
      rx_cnt += int'(rx_valid);
    end
    chk("rst.no_rx_valid", rx_cnt, 0);
    chk("rst.idle_sclk", 32'(sclk), 32'd1);
    run_frame("post_rst", 1'b1, 1'b0, 4'd7, 16'h00C3, 1'b0, 16'h0081, 1'b0, 16'h0081, 16'h00C3, 35);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
